// File: rtl/aoi_chk_pkg.sv
// Shared types and constants for the AND-OR response checker.
// Holds the FSM encoding and the reference function Z = A&C | B&D.
package aoi_chk_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam int CNT_W   = $clog2(NUM_VEC + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // v is {A,B,C,D}, A in the MSB
  function automatic logic aoi_expected(
    input logic [VEC_W-1:0] v
  );
    return (v[3] & v[1]) | (v[2] & v[0]);
  endfunction

endpackage

// File: rtl/aoi_ref_model.sv
// Combinational golden model of the AND-OR block.
// Used by the checker to derive the expected response per vector.
module aoi_ref_model
  import aoi_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic expected
);

  assign expected = aoi_expected({a, b, c, d});

endmodule

// File: rtl/aoi_response_checker.sv
// Exhaustive 16-vector sweep checker for Z = A&C | B&D.
// Each vector is held SETTLE+1 cycles; Z is sampled on the last edge.
module aoi_response_checker
  import aoi_chk_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Z,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam int WW =
    (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);
  localparam logic [WW-1:0] SETTLE_W =
    WW'(SETTLE);
  localparam logic [VEC_W-1:0] LAST_VEC =
    VEC_W'(NUM_VEC - 1);

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic [WW-1:0]      wait_cnt;
  logic               expected;
  logic               mismatch;
  logic               sample;
  logic [CNT_W-1:0]   err_next;

  aoi_ref_model u_ref (
    .a        (vec[3]),
    .b        (vec[2]),
    .c        (vec[1]),
    .d        (vec[0]),
    .expected (expected)
  );

  assign {A, B, C, D} = vec;

  // 4-state compare so an X or Z response is a mismatch
  assign mismatch = (Z !== expected);
  assign sample   = (wait_cnt == SETTLE_W);
  assign err_next = err_count + CNT_W'(mismatch);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= '0;
      wait_cnt         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state            <= RUN;
            vec              <= '0;
            wait_cnt         <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        RUN: begin
          if (!sample) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= vec;
              first_fail_valid <= 1'b1;
            end
            if (vec == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              vec      <= vec + 1'b1;
              wait_cnt <= '0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aoi_response_checker.sv
// Bench for aoi_response_checker: SETTLE=0 and SETTLE=2 instances
// driven by fault-injecting device models, checked against a sweep model.
module tb_aoi_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic       z     [2];
  logic       a     [2];
  logic       b     [2];
  logic       c     [2];
  logic       d     [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [4:0] err   [2];
  logic [3:0] ffv   [2];
  logic       ffval [2];
  int         mode  [2];
  logic [15:0] mask [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // index 0: SETTLE=0, index 1: SETTLE=2
  aoi_response_checker #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .Z(z[0]),
    .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .first_fail_vec(ffv[0]),
    .first_fail_valid(ffval[0])
  );

  aoi_response_checker #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .Z(z[1]),
    .A(a[1]), .B(b[1]), .C(c[1]), .D(d[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .first_fail_vec(ffv[1]),
    .first_fail_valid(ffval[1])
  );

  function automatic bit ref_exp(input int v);
    return bit'((((v >> 3) & (v >> 1)) | ((v >> 2) & v)) & 1);
  endfunction

  // device under check: 0 good, 1 stuck0, 2 stuck1, 3 inverted, 4 masked flips
  function automatic logic dev_z(input int m, input logic [3:0] v,
                                 input logic [15:0] mk);
    case (m)
      0:       return ref_exp(int'(v));
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return !ref_exp(int'(v));
      default: return ref_exp(int'(v)) ^ mk[v];
    endcase
  endfunction

  assign z[0] = dev_z(mode[0], {a[0], b[0], c[0], d[0]}, mask[0]);
  assign z[1] = dev_z(mode[1], {a[1], b[1], c[1], d[1]}, mask[1]);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int vec_of(input int s);
    return int'({a[s], b[s], c[s], d[s]});
  endfunction

  task automatic check_reset(input int s);
    check("rst_vec", vec_of(s), 0);
    check("rst_busy", busy[s], 0);
    check("rst_done", done[s], 0);
    check("rst_pass", pass[s], 0);
    check("rst_err", err[s], 0);
    check("rst_ffv", ffv[s], 0);
    check("rst_ffval", ffval[s], 0);
  endtask

  task automatic check_result(input int s, input int e, input int f,
                              input bit fv, input bit p);
    check("err_count", err[s], e);
    check("first_fail_vec", ffv[s], f);
    check("first_fail_valid", ffval[s], fv);
    check("pass", pass[s], p);
  endtask

  // smode: 0 release start, 1 random start during RUN
  task automatic run_sweep(input int s, input int m, input logic [15:0] mk,
                           input int smode);
    int st;
    int n;
    int j;
    int bad_vec;
    int bad_busy;
    st = (s != 0) ? 2 : 0;
    n = 16 * (st + 1);
    bad_vec = 0;
    bad_busy = 0;
    mode[s] = m;
    mask[s] = mk;
    @(negedge clk);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = (smode == 1) ? 1'($urandom) : 1'b0;
    j = 0;
    while (!done[s] && j <= n + 4) begin
      if (vec_of(s) != j / (st + 1)) bad_vec++;
      if (!busy[s]) bad_busy++;
      @(negedge clk);
      j++;
      if (smode == 1) start[s] = 1'($urandom);
    end
    start[s] = 1'b0;
    check("done_latency", j, n);
    check("vec_walk", bad_vec, 0);
    check("busy_in_run", bad_busy, 0);
    check("busy_at_done", busy[s], 0);
    check("hold_last_vec", vec_of(s), 15);
    @(negedge clk);
    check("done_one_cycle", done[s], 0);
  endtask

  typedef struct {
    int          s;
    int          m;
    int          e;
    int          f;
    bit          fv;
    bit          p;
  } tvec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tvec_t tab [6];
    int j;
    int seen;
    int ee;
    int ef;
    logic [15:0] mk;
    int s;

    tab[0] = '{1, 0, 0, 0, 1'b0, 1'b1};
    tab[1] = '{1, 1, 7, 5, 1'b1, 1'b0};
    tab[2] = '{1, 2, 9, 0, 1'b1, 1'b0};
    tab[3] = '{0, 3, 16, 0, 1'b1, 1'b0};
    tab[4] = '{0, 0, 0, 0, 1'b0, 1'b1};
    tab[5] = '{0, 1, 7, 5, 1'b1, 1'b0};

    rst_n = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mode[0] = 0;
    mode[1] = 0;
    mask[0] = '0;
    mask[1] = '0;
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      run_sweep(tab[i].s, tab[i].m, 16'h0, 0);
      check_result(tab[i].s, tab[i].e, tab[i].f, tab[i].fv, tab[i].p);
    end

    // random flip masks, start toggling during RUN
    for (int it = 0; it < 10; it++) begin
      s = int'($urandom_range(0, 1));
      mk = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      ee = $countones(mk);
      ef = 0;
      for (int v = 15; v >= 0; v--) if (mk[v]) ef = v;
      run_sweep(s, 4, mk, 1);
      check_result(s, ee, ef, mk != 0, mk == 0);
    end

    // start held high: back-to-back sweeps
    mode[1] = 1;
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    j = 0;
    while (!done[1] && j <= 60) begin
      @(negedge clk);
      j++;
    end
    check("held_latency", j, 48);
    check("held_err", err[1], 7);
    @(negedge clk);
    check("held_idle_busy", busy[1], 0);
    check("held_idle_done", done[1], 0);
    @(negedge clk);
    check("restart_busy", busy[1], 1);
    check("restart_err_clr", err[1], 0);
    check("restart_vec0", vec_of(1), 0);
    start[1] = 1'b0;
    j = 0;
    while (!done[1] && j <= 60) begin
      @(negedge clk);
      j++;
    end
    check("restart_latency", j, 48);
    check_result(1, 7, 5, 1'b1, 1'b0);

    // abort mid-sweep with reset at vec 7
    mode[1] = 0;
    repeat (2) @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    j = 0;
    while (vec_of(1) != 7 && j < 100) begin
      @(negedge clk);
      j++;
    end
    check("reach_vec7", vec_of(1), 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset(1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done[1] || busy[1]) seen++;
    end
    check("no_done_after_abort", seen, 0);
    run_sweep(1, 0, 16'h0, 0);
    check_result(1, 0, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
